// File: rtl/conv2d_kernel_scheduler_if.sv
// ---------------------------------------------------------------------------
// conv2d_kernel_scheduler_if
//  Handshake bundle between the Conv2d layer scheduler and the blocks it
//  sequences: the kernel BRAM controller (load / read-address advance) and
//  the MAC engine (per-input-channel start / done).
//
//  Signals
//   load_BRAM_dina     sched -> bram  1-cycle pulse: load one kernel set
//   last_loading_1ker  bram  -> sched kernel-load complete strobe
//   update_BRAM_doutb  sched -> bram  1-cycle pulse: advance read address
//   last_channel       bram  -> sched read-address wrap strobe
//   mac_start          sched -> mac   1-cycle pulse: process current channel
//   mac_done           mac   -> sched current channel finished
//
//  Modports
//   master : the scheduler side
//   slave  : the kernel BRAM controller / MAC engine side
// ---------------------------------------------------------------------------
interface conv2d_kernel_scheduler_if;

   logic load_BRAM_dina;
   logic last_loading_1ker;
   logic update_BRAM_doutb;
   logic last_channel;
   logic mac_start;
   logic mac_done;

   modport master (
      output load_BRAM_dina,
      output update_BRAM_doutb,
      output mac_start,
      input  last_loading_1ker,
      input  last_channel,
      input  mac_done
   );

   modport slave (
      input  load_BRAM_dina,
      input  update_BRAM_doutb,
      input  mac_start,
      output last_loading_1ker,
      output last_channel,
      output mac_done
   );

endinterface

// File: rtl/conv2d_kernel_scheduler.sv
// ---------------------------------------------------------------------------
// conv2d_kernel_scheduler
//  Layer-level sequencer for the Conv2d kernel path. For every output channel
//  it requests one full kernel load from the kernel BRAM controller, then
//  steps the MAC engine through every input channel, advancing the kernel
//  read address between channels. layer_done pulses after the last output
//  channel. All outputs are registered (Moore): each is a flop loaded from a
//  decode of the next state.
//
//  Parameters
//   CH_W     width of channel counts and indices
//   ADV_GAP  cycles from an update_BRAM_doutb pulse to the next action; must
//            be >= 4 so the kernel BRAM controller is idle again in time
//
//  Ports
//   clk           clock
//   Reset         synchronous, active-low reset
//   start         1-cycle pulse, sampled only while idle
//   channel_size  input channels per kernel, latched on accepted start
//   num_out_ch    output channels in the layer, latched on accepted start
//   kif           handshake bundle to kernel BRAM controller and MAC engine
//   busy          high from accepted start through the layer_done cycle
//   layer_done    1-cycle pulse at end of layer
//   out_ch_idx    current output channel, 0-based
//   in_ch_idx     current input channel, 0-based
//   seq_err       sticky: last_channel disagreed with the internal count
// ---------------------------------------------------------------------------
module conv2d_kernel_scheduler #(
   parameter int CH_W    = 9,
   parameter int ADV_GAP = 4
) (
   input  logic                              clk,
   input  logic                              Reset,
   input  logic                              start,
   input  logic [CH_W-1:0]                   channel_size,
   input  logic [CH_W-1:0]                   num_out_ch,
   conv2d_kernel_scheduler_if.master         kif,
   output logic                              busy,
   output logic                              layer_done,
   output logic [CH_W-1:0]                   out_ch_idx,
   output logic [CH_W-1:0]                   in_ch_idx,
   output logic                              seq_err
);

   // The gap counter runs 0 .. ADV_GAP-2 while in S_GAP, so S_GAP lasts
   // ADV_GAP-1 cycles and the next action lands ADV_GAP cycles after the
   // update pulse.
   localparam int              GAP_W    = (ADV_GAP > 2) ? $clog2(ADV_GAP - 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ADV_GAP - 2);
   localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
   localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
   localparam logic [CH_W-1:0]  CH_ONE   = {{(CH_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_REQ_LOAD  = 4'd1,
      S_WAIT_LOAD = 4'd2,
      S_MAC_START = 4'd3,
      S_WAIT_MAC  = 4'd4,
      S_ADV       = 4'd5,
      S_GAP       = 4'd6,
      S_NEXT_OC   = 4'd7,
      S_DONE      = 4'd8
   } state_e;

   state_e           state_q,      state_d;
   logic [CH_W-1:0]  cs_q,         cs_d;
   logic [CH_W-1:0]  noc_q,        noc_d;
   logic [CH_W-1:0]  out_idx_q,    out_idx_d;
   logic [CH_W-1:0]  in_idx_q,     in_idx_d;
   logic [GAP_W-1:0] gap_q,        gap_d;
   logic             lc_seen_q,    lc_seen_d;
   logic             seq_err_q,    seq_err_d;
   logic             load_q,       load_d;
   logic             upd_q,        upd_d;
   logic             mac_q,        mac_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;

   logic             zero_start_s;
   logic             is_last_s;
   logic             lc_eff_s;

   // Next-state, counter and registered-output decode.
   always_comb begin
      state_d      = state_q;
      cs_d         = cs_q;
      noc_d        = noc_q;
      out_idx_d    = out_idx_q;
      in_idx_d     = in_idx_q;
      gap_d        = gap_q;
      lc_seen_d    = lc_seen_q;
      seq_err_d    = seq_err_q;
      zero_start_s = 1'b0;
      is_last_s    = (in_idx_q == (cs_q - CH_ONE));
      // The strobe may arrive on the very cycle the gap ends.
      lc_eff_s     = lc_seen_q | kif.last_channel;

      case (state_q)
         S_IDLE: begin
            if (start == 1'b1) begin
               if ((channel_size != CH_ZERO) && (num_out_ch != CH_ZERO)) begin
                  cs_d      = channel_size;
                  noc_d     = num_out_ch;
                  out_idx_d = CH_ZERO;
                  in_idx_d  = CH_ZERO;
                  seq_err_d = 1'b0;
                  state_d   = S_REQ_LOAD;
               end else begin
                  // Empty layer: report completion without touching the datapath.
                  zero_start_s = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_REQ_LOAD: begin
            state_d = S_WAIT_LOAD;
         end

         S_WAIT_LOAD: begin
            if (kif.last_loading_1ker == 1'b1) begin
               state_d = S_MAC_START;
            end else begin
               state_d = S_WAIT_LOAD;
            end
         end

         S_MAC_START: begin
            // mac_done is not looked at here, so a stale done from the
            // previous channel cannot skip the current one.
            state_d = S_WAIT_MAC;
         end

         S_WAIT_MAC: begin
            if (kif.mac_done == 1'b1) begin
               state_d = S_ADV;
            end else begin
               state_d = S_WAIT_MAC;
            end
         end

         S_ADV: begin
            gap_d     = GAP_ZERO;
            lc_seen_d = 1'b0;
            state_d   = S_GAP;
         end

         S_GAP: begin
            lc_seen_d = lc_eff_s;
            if (gap_q == GAP_LAST) begin
               // The internal count decides the sequence; the strobe only
               // flags a disagreement.
               if (lc_eff_s != is_last_s) begin
                  seq_err_d = 1'b1;
               end else begin
                  seq_err_d = seq_err_q;
               end
               if (is_last_s == 1'b1) begin
                  in_idx_d = CH_ZERO;
                  state_d  = S_NEXT_OC;
               end else begin
                  in_idx_d = in_idx_q + CH_ONE;
                  state_d  = S_MAC_START;
               end
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end

         S_NEXT_OC: begin
            if (out_idx_q == (noc_q - CH_ONE)) begin
               state_d = S_DONE;
            end else begin
               out_idx_d = out_idx_q + CH_ONE;
               state_d   = S_REQ_LOAD;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the state being entered so that each
      // registered pulse lines up with its state.
      load_d = (state_d == S_REQ_LOAD);
      mac_d  = (state_d == S_MAC_START);
      upd_d  = (state_d == S_ADV);
      done_d = (state_d == S_DONE) | zero_start_s;
      busy_d = (state_d != S_IDLE);
   end

   // State, configuration, counter and output registers.
   always_ff @(posedge clk) begin
      if (Reset == 1'b0) begin
         state_q   <= S_IDLE;
         cs_q      <= CH_ZERO;
         noc_q     <= CH_ZERO;
         out_idx_q <= CH_ZERO;
         in_idx_q  <= CH_ZERO;
         gap_q     <= GAP_ZERO;
         lc_seen_q <= 1'b0;
         seq_err_q <= 1'b0;
         load_q    <= 1'b0;
         upd_q     <= 1'b0;
         mac_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cs_q      <= cs_d;
         noc_q     <= noc_d;
         out_idx_q <= out_idx_d;
         in_idx_q  <= in_idx_d;
         gap_q     <= gap_d;
         lc_seen_q <= lc_seen_d;
         seq_err_q <= seq_err_d;
         load_q    <= load_d;
         upd_q     <= upd_d;
         mac_q     <= mac_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign kif.load_BRAM_dina    = load_q;
   assign kif.update_BRAM_doutb = upd_q;
   assign kif.mac_start         = mac_q;
   assign busy                  = busy_q;
   assign layer_done            = done_q;
   assign out_ch_idx            = out_idx_q;
   assign in_ch_idx             = in_idx_q;
   assign seq_err               = seq_err_q;

endmodule
